// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO decode value, IO register
// addresses and the cycle-counter width.
package mem_io_responder_pkg;
  localparam logic [1:0]  IO_DEC       = 2'b11;
  localparam logic [17:0] IO_TX_ADDR   = 18'h30000;
  localparam logic [17:0] IO_STOP_ADDR = 18'h30004;
  localparam int          CNT_W        = 32;
endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte-wide circular FIFO with count, full/empty flags and a registered
// near-full flag (two or fewer free entries). Pushing into a full FIFO only succeeds with a same-cycle pop.
module byte_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_afull
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_afull;
  logic          w_pop_ok;
  logic          w_push_ok;
  logic [CW-1:0] w_count_next;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok)
      w_count_next = r_count + CW'(1);
    else if (!w_push_ok && w_pop_ok)
      w_count_next = r_count - CW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_afull <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_next;
      r_afull <= (w_count_next >= CW'(DEPTH - 2));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_afull = r_afull;
endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus memory-mapped UART TX/RX, stop register and cycle counter.
// Define MEM_IO_RX_EN to enable the UART RX read path at 0x30000.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        program_stop
);
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic [7:0]       r_ram [2**RAM_ADDR_W];
  logic [7:0]       r_din;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_snap;
  logic             r_stop;

  logic [17:0]      w_addr;
  logic             w_is_io;
  logic             w_wr_en;
  logic             w_rd_en;
  logic             w_tx_hit;
  logic             w_stop_hit;
  logic             w_cnt_hit;
  logic             w_push;
  logic [7:0]       w_push_data;
  logic             w_pop;
  logic [7:0]       w_rx_byte;
  logic [7:0]       w_rd_data;
  logic [TX_CW-1:0] w_fifo_count;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_unused;
  logic             w_unused_rx;

  assign w_addr     = mem_a[17:0];
  assign w_is_io    = (w_addr[17:16] == IO_DEC);
  assign w_wr_en    = rdy_in && mem_wr && !r_stop;
  assign w_rd_en    = rdy_in && !mem_wr;
  assign w_tx_hit   = (w_addr == IO_TX_ADDR);
  assign w_stop_hit = (w_addr == IO_STOP_ADDR);
  assign w_cnt_hit  = (w_addr[17:2] == IO_STOP_ADDR[17:2]);

  // A write to the stop register enqueues a 0x00 terminator byte.
  assign w_push      = w_wr_en && w_is_io && ((w_tx_hit && (mem_dout != 8'h00)) || w_stop_hit);
  assign w_push_data = w_stop_hit ? 8'h00 : mem_dout;
  assign w_pop       = tx_valid && tx_ready;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (tx_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_afull (io_buffer_full)
  );

  assign tx_valid = !w_fifo_empty;

`ifdef MEM_IO_RX_EN
  assign w_rx_byte   = rx_valid ? rx_data : 8'h00;
  assign rx_pop      = w_rd_en && w_tx_hit && rx_valid && !rst_in;
  assign w_unused_rx = 1'b0;
`else
  assign w_rx_byte   = 8'h00;
  assign rx_pop      = 1'b0;
  assign w_unused_rx = &{1'b0, rx_valid, rx_data};
`endif

  assign w_unused = &{1'b0, mem_a[31:18], w_fifo_count, w_fifo_full, w_unused_rx};

  always_comb begin
    w_rd_data = 8'h00;
    if (!w_is_io) begin
      w_rd_data = r_ram[mem_a[RAM_ADDR_W-1:0]];
    end else if (w_tx_hit) begin
      w_rd_data = w_rx_byte;
    end else if (w_cnt_hit) begin
      case (w_addr[1:0])
        2'd0:    w_rd_data = r_cnt[7:0];
        2'd1:    w_rd_data = r_snap[15:8];
        2'd2:    w_rd_data = r_snap[23:16];
        default: w_rd_data = r_snap[31:24];
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_wr_en && !w_is_io) r_ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
  end

  // Byte 0 of the counter is returned live while the whole word is captured,
  // so bytes 1..3 read later stay coherent with it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_din  <= 8'h00;
      r_cnt  <= '0;
      r_snap <= '0;
      r_stop <= 1'b0;
    end else if (rdy_in) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_rd_en) begin
        r_din <= w_rd_data;
        if (w_cnt_hit && (w_addr[1:0] == 2'd0)) r_snap <= r_cnt;
      end
      if (w_wr_en && w_stop_hit) r_stop <= 1'b1;
    end
  end

  assign mem_din      = r_din;
  assign program_stop = r_stop;
endmodule
